// File: rtl/pixel_spike_encoder.sv
// rtl/pixel_spike_encoder.sv - rate encoder turning a pixel group into TIMESTEPS spike vectors
module pixel_spike_encoder #(
    parameter int         NUM_NEURONS = 16,
    parameter int         TIMESTEPS   = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             pixel_data,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    input  logic                   stoch_en,
    output logic [NUM_NEURONS-1:0] spike_out,
    output logic                   spike_valid,
    input  logic                   spike_ready,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int LW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int SW = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
    localparam logic [LW-1:0] LOAD_LAST = LW'(NUM_NEURONS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(TIMESTEPS - 1);

    typedef enum logic {LOAD, EMIT} state_t;

    state_t        state;
    logic [LW-1:0] load_cnt;
    logic [SW-1:0] step_cnt;
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_next;
    logic          mode;
    logic          frame_done_r;
    logic [7:0]    pix      [NUM_NEURONS];
    logic [7:0]    acc      [NUM_NEURONS];
    logic [8:0]    sum      [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spike_vec;

    // x^8+x^6+x^5+x^4+1, shifted left with the feedback entering bit 0
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // Each lane XORs the shared LFSR with its own constant so lanes decorrelate
    always_comb begin
        spike_vec = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, pix[i]};
            if (mode)
                spike_vec[i] = pix[i] > (lfsr ^ 8'(i * 32'h1D));
            else
                spike_vec[i] = sum[i][8];
        end
    end

    assign pixel_ready = (state == LOAD);
    assign spike_valid = (state == EMIT);
    assign busy        = (state == EMIT);
    assign frame_done  = frame_done_r;
    assign spike_out   = (state == EMIT) ? spike_vec : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            load_cnt     <= '0;
            step_cnt     <= '0;
            lfsr         <= LFSR_SEED;
            mode         <= 1'b0;
            frame_done_r <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pix[i] <= 8'h00;
                acc[i] <= 8'h80;
            end
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                LOAD: begin
                    if (pixel_valid) begin
                        pix[load_cnt] <= pixel_data;
                        if (load_cnt == LOAD_LAST) begin
                            load_cnt <= '0;
                            mode     <= stoch_en;
                            step_cnt <= '0;
                            state    <= EMIT;
                            for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= 8'h80;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (spike_ready) begin
                        lfsr <= lfsr_next;
                        if (!mode) begin
                            for (int i = 0; i < NUM_NEURONS; i++) acc[i] <= sum[i][7:0];
                        end
                        if (step_cnt == STEP_LAST) begin
                            step_cnt     <= '0;
                            state        <= LOAD;
                            frame_done_r <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_spike_encoder.sv
// tb/tb_pixel_spike_encoder.sv - self-checking bench for pixel_spike_encoder
module tb_pixel_spike_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pixel_data = 8'h00;
    logic        pixel_valid = 1'b0;
    logic        pixel_ready;
    logic        stoch_en = 1'b0;
    logic [15:0] spike_out;
    logic        spike_valid;
    logic        spike_ready = 1'b0;
    logic        frame_done;
    logic        busy;

    pixel_spike_encoder #(.NUM_NEURONS(16), .TIMESTEPS(8), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .stoch_en(stoch_en), .spike_out(spike_out),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .frame_done(frame_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: group-level state plus closed-form spike rules
    bit         m_init = 0;
    bit         m_load = 1;
    bit         m_fd = 0;
    bit         m_mode = 0;
    int         m_cnt = 0;
    int         m_step = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_pix [16];

    function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    // Deterministic: the spike count after s steps is floor((128 + p*s) / 256)
    function automatic logic [15:0] exp_vec();
        logic [15:0] v = '0;
        if (!m_load) begin
            for (int i = 0; i < 16; i++) begin
                int p = int'(m_pix[i]);
                if (m_mode) v[i] = m_pix[i] > (m_lfsr ^ 8'((i * 29) % 256));
                else        v[i] = ((128 + p * (m_step + 1)) / 256) > ((128 + p * m_step) / 256);
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_load = 1; m_fd = 0; m_cnt = 0; m_step = 0; m_lfsr = 8'hA5; m_mode = 0;
            for (int i = 0; i < 16; i++) m_pix[i] = 8'h00;
        end else if (m_init) begin
            m_fd = 0;
            if (m_load) begin
                if (pixel_valid) begin
                    m_pix[m_cnt] = pixel_data;
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_cnt = 0; m_mode = stoch_en; m_step = 0; m_load = 0;
                    end
                end
            end else if (spike_ready) begin
                m_lfsr = lfsr_adv(m_lfsr);
                m_step++;
                if (m_step == 8) begin
                    m_step = 0; m_load = 1; m_fd = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("pixel_ready", pixel_ready, m_load);
            check("spike_valid", spike_valid, !m_load);
            check("busy", busy, !m_load);
            check("frame_done", frame_done, m_fd);
            check("spike_out", spike_out, exp_vec());
        end
    end

    // Collector: handshakes, captured vectors, stall hold, timing marks
    int          cyc = 0;
    int          n_hs = 0;
    int          n_fd = 0;
    int          cap_idx = 0;
    logic [15:0] cap [64];
    bit          prev_stall = 0;
    logic [15:0] prev_vec = '0;
    int          last_hs_cyc = 0;
    bit          watch = 0;
    int          acc_cyc = -100;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_stall && spike_valid) check("stall_hold", spike_out, prev_vec);
        prev_stall = spike_valid && !spike_ready;
        prev_vec   = spike_out;
        if (spike_valid && spike_ready && !rst) begin
            n_hs++;
            last_hs_cyc = cyc;
            if (cap_idx < 64) cap[cap_idx] = spike_out;
            cap_idx++;
        end
        if (frame_done) n_fd++;
        if (watch && pixel_valid && pixel_ready) begin
            acc_cyc = cyc;
            watch = 0;
        end
    end

    logic [7:0] grp [16];

    task automatic send_pixel(input logic [7:0] d, input bit gap);
        int t = 0;
        if (gap) begin
            pixel_valid = 1'b0;
            @(posedge clk); #1;
        end
        pixel_data = d;
        pixel_valid = 1'b1;
        @(negedge clk);
        while (!pixel_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("pixel_accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic load_group(input bit gap, input bit hold);
        cap_idx = 0;
        for (int i = 0; i < 16; i++) send_pixel(grp[i], gap);
        if (!hold) pixel_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int c = 0;
        bit done = 0;
        int h0 = n_hs;
        int f0 = n_fd;
        while (!done && c < 200) begin
            spike_ready = toggle ? ((c % 3) == 0) : 1'b1;
            @(negedge clk);
            if (frame_done) done = 1;
            @(posedge clk); #1;
            c++;
        end
        spike_ready = 1'b0;
        check("drain_done", done, 1);
        check("vectors_per_group", n_hs - h0, 8);
        check("frame_done_pulses", n_fd - f0, 1);
    endtask

    task automatic set_pattern();
        for (int i = 0; i < 16; i++) grp[i] = 8'h00;
        grp[1] = 8'd32; grp[2] = 8'd128; grp[3] = 8'd255;
    endtask

    task automatic check_det_caps();
        logic [7:0]  el [4];
        logic [7:0]  w;
        logic [15:0] rest = '0;
        el[0] = 8'h00; el[1] = 8'h08; el[2] = 8'h55; el[3] = 8'hFF;
        check("cap_count", cap_idx, 8);
        for (int l = 0; l < 4; l++) begin
            w = '0;
            for (int s = 0; s < 8; s++) w[s] = cap[s][l];
            check($sformatf("lane%0d_steps", l), w, el[l]);
        end
        for (int s = 0; s < 8; s++) rest |= cap[s];
        check("lanes4_15_silent", rest[15:4], 12'h000);
    endtask

    initial begin
        int h0;
        logic [15:0] orv;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pixel_ready", pixel_ready, 1);
        check("rst_spike_valid", spike_valid, 0);
        check("rst_spike_out", spike_out, 16'h0000);
        check("rst_frame_done", frame_done, 0);
        @(posedge clk); #1;

        // Deterministic rate pattern, free-flowing output
        set_pattern();
        stoch_en = 1'b0;
        load_group(0, 0);
        drain(0);
        check_det_caps();
        @(negedge clk);
        check("post_frame_pixel_ready", pixel_ready, 1);
        @(posedge clk); #1;

        // Same pattern with back-pressure 1,0,0,...
        load_group(0, 0);
        drain(1);
        check_det_caps();

        // Stochastic groups; stoch_en flips mid-emit without effect
        h0 = n_hs;
        stoch_en = 1'b1;
        for (int i = 0; i < 16; i++) grp[i] = 8'hFF;
        load_group(0, 0);
        stoch_en = 1'b0;
        drain(0);
        check("stoch_255_step0", cap[0], 16'hFFFF);
        stoch_en = 1'b1;
        for (int i = 0; i < 16; i++) grp[i] = 8'h00;
        load_group(0, 0);
        stoch_en = 1'b0;
        drain(0);
        orv = '0;
        for (int s = 0; s < 8; s++) orv |= cap[s];
        check("stoch_zero_silent", orv, 16'h0000);
        check("stoch_lfsr_advances", n_hs - h0, 16);
        stoch_en = 1'b1;
        for (int i = 0; i < 16; i++) grp[i] = 8'((i * 16) + 8);
        load_group(0, 0);
        drain(0);

        // Reset during emission, after three handshakes
        set_pattern();
        stoch_en = 1'b0;
        load_group(0, 0);
        h0 = n_hs;
        spike_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        spike_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_handshakes", n_hs - h0, 3);
        @(negedge clk);
        check("abort_pixel_ready", pixel_ready, 1);
        check("abort_spike_valid", spike_valid, 0);
        check("abort_frame_done", frame_done, 0);
        @(posedge clk); #1;

        // Fresh stochastic group with gaps must start from the seed
        stoch_en = 1'b1;
        for (int i = 0; i < 16; i++) grp[i] = 8'((i * 16) + 8);
        load_group(1, 0);
        drain(0);
        check("reseed_step0", cap[0], 16'hCDE0);
        stoch_en = 1'b0;
        set_pattern();
        load_group(0, 0);
        drain(0);
        check_det_caps();

        // pixel_valid held through EMIT with the next group waiting
        set_pattern();
        stoch_en = 1'b0;
        spike_ready = 1'b1;
        load_group(0, 1);
        watch = 1;
        for (int i = 0; i < 16; i++) grp[i] = 8'(i * 17);
        load_group(0, 0);
        check("queued_accept_latency", acc_cyc - last_hs_cyc, 1);
        drain(0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule

// File: doc/pixel_spike_encoder.md
Name: pixel_spike_encoder

Overview:
- Front-end rate encoder for the neuron array: turns a grayscale pixel stream into per-neuron spike vectors. It is the transmit side feeding neuron spike inputs; the spike accumulator and detector sit downstream.
- Collects one group of NUM_NEURONS pixels over a valid/ready handshake.
- Emits TIMESTEPS spike vectors over a second valid/ready handshake. Coding is deterministic (accumulate-and-fire) or stochastic (LFSR compare).

Parameters:
- NUM_NEURONS, 16, pixels per group = spike lanes.
- TIMESTEPS, 8, spike vectors emitted per group (>=1).
- LFSR_SEED, 8'hA5, non-zero reset value of the stochastic LFSR.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- pixel_data  in  8  grayscale pixel.
- pixel_valid  in  1  pixel_data valid.
- pixel_ready  out  1  encoder accepts a pixel this cycle.
- stoch_en  in  1  0 = deterministic, 1 = stochastic; sampled when a group completes loading.
- spike_out  out  NUM_NEURONS  spike vector, bit i drives neuron i.
- spike_valid  out  1  spike_out valid.
- spike_ready  in  1  downstream consumes spike_out.
- frame_done  out  1  one-cycle pulse after the last vector of a group is consumed.
- busy  out  1  high in EMIT.

Behaviour:
- Reset (rst high at posedge) has priority over everything and discards any partial group or emission. State <- LOAD, load_cnt <- 0, step_cnt <- 0, LFSR <- LFSR_SEED, all accumulators <- 8'h80, pixel registers <- 0. Outputs after reset: pixel_ready=1, spike_valid=0, spike_out=0, frame_done=0, busy=0.
- State LOAD:
  - pixel_ready=1, spike_valid=0.
  - On pixel_valid&pixel_ready: pix[load_cnt] <- pixel_data and load_cnt++. Pixels fill lanes in arrival order, lane 0 first.
  - On accepting pixel NUM_NEURONS-1: load_cnt <- 0, mode <- stoch_en, acc[all] <- 8'h80, step_cnt <- 0, go to EMIT.
  - Gaps in pixel_valid only stall loading.
- State EMIT:
  - pixel_ready=0, spike_valid=1, busy=1.
  - spike_out is combinational from registers only, so it stays stable while spike_valid & !spike_ready.
  - Deterministic lane i: sum_i = {1'b0,acc_i} + {1'b0,pix_i} (9-bit); spike_out[i] = sum_i[8].
  - Stochastic lane i: spike_out[i] = (pix_i > (lfsr ^ r_i)), where r_i = (i*8'h1D) mod 256; the comparison is unsigned.
  - On spike_valid&spike_ready: acc_i <- sum_i[7:0] in deterministic mode only; LFSR advances one step; step_cnt++.
  - On the handshake with step_cnt == TIMESTEPS-1: go to LOAD, step_cnt <- 0, frame_done=1 on the next cycle only.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0. It advances only on spike handshakes, never reaches zero, and is not reseeded between groups.
- Latency:
  - Last pixel accepted at cycle k → spike_valid=1 at k+1.
  - Final spike handshake at cycle m → pixel_ready=1 and frame_done=1 at m+1.
  - There is no overlap of load and emit.
- Width rules: 8-bit unsigned pixels and accumulators; the carry out of the 9-bit sum is the spike and the residual wraps modulo 256. load_cnt is clog2(NUM_NEURONS) wide; step_cnt is max(1,clog2(TIMESTEPS)) wide.
- Deterministic rate (TIMESTEPS=8, acc start 0x80): pixel 0 → 0 spikes; 32 → 1 spike at step 3; 128 → 4 spikes at steps 0,2,4,6; 255 → 8 spikes.
- Simultaneous pixel_valid during EMIT: ignored, not accepted.
- stoch_en changes during EMIT: no effect until the next group.

Test Plan:
- Reset then idle → pixel_ready=1, spike_valid=0, spike_out=0, frame_done=0; LFSR=8'hA5.
- stoch_en=0; load 16 pixels lanes 0..3 = 0,32,128,255 with the rest 0; spike_ready=1 → spike_valid one cycle after the 16th pixel. Exactly 8 vectors: lane0 never spikes, lane1 only at step 3, lane2 at steps 0,2,4,6, lane3 every step. frame_done pulses once, then pixel_ready=1.
- Same load with spike_ready toggled 1,0,0,1,... → spike_out held constant while stalled, still exactly 8 vectors, same per-step pattern.
- stoch_en=1, all pixels 255, then all pixels 0 → every lane spikes on all 8 steps (LFSR is never 0xFF^r_i... check golden model), then no lane spikes. The LFSR sequence matches the reference model across both groups, with 16 advances total.
- Assert rst after 3 of 8 spike handshakes → next cycle: LOAD, spike_valid=0, no frame_done. A fresh 16-pixel group then encodes from acc=0x80 and LFSR=8'hA5.
- pixel_valid held high through EMIT with a second group queued → no pixel accepted during EMIT. The first pixel of the second group is accepted one cycle after the final spike handshake.
